// File: rtl/dds_sweep_ctrl_if.sv
// Control/status bundle between the register block (master) and the DDS sweep sequencer (slave).
interface dds_sweep_ctrl_if #(
  parameter int FTW_W   = 32,
  parameter int DWELL_W = 16
);
  logic [FTW_W-1:0]   cfg_start_ftw;
  logic [FTW_W-1:0]   cfg_stop_ftw;
  logic [FTW_W-1:0]   cfg_step_ftw;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [1:0]         cfg_mode;
  logic               start;
  logic               abort;
  logic [FTW_W-1:0]   ftw_out;
  logic               ftw_valid;
  logic               phase_clr;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output cfg_start_ftw, cfg_stop_ftw, cfg_step_ftw, cfg_dwell, cfg_mode, start, abort,
    input  ftw_out, ftw_valid, phase_clr, busy, done, err
  );

  modport slave (
    input  cfg_start_ftw, cfg_stop_ftw, cfg_step_ftw, cfg_dwell, cfg_mode, start, abort,
    output ftw_out, ftw_valid, phase_clr, busy, done, err
  );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer: steps the DDS tuning word from start to stop with a fixed dwell,
// in single, sawtooth-repeat or triangle mode.
module dds_sweep_ctrl #(
  parameter int FTW_W   = 32,
  parameter int DWELL_W = 16
) (
  input  logic            CLK,
  input  logic            RST,
  dds_sweep_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_t;

  state_t             r_state;
  logic [FTW_W-1:0]   r_start;
  logic [FTW_W-1:0]   r_stop;
  logic [FTW_W-1:0]   r_step;
  logic [1:0]         r_mode;
  logic               r_single;
  logic [DWELL_W-1:0] r_reload;
  logic [DWELL_W-1:0] r_cnt;
  logic               r_dir_down;
  logic [FTW_W-1:0]   r_ftw;
  logic               r_valid;
  logic               r_pclr;
  logic               r_busy;
  logic               r_done;
  logic               r_err;

  logic [DWELL_W-1:0] w_dwell_eff;
  logic               w_dwell_is1;
  logic [DWELL_W-1:0] w_reload;
  logic               w_cfg_bad;
  logic [FTW_W:0]     w_up_sum;
  logic [FTW_W:0]     w_dn_diff;
  logic [FTW_W-1:0]   w_up_next;
  logic [FTW_W-1:0]   w_dn_next;
  logic [FTW_W-1:0]   w_step_ftw;
  logic               w_step_dir_down;
  logic               w_step_fin;

  // The STEP cycle is one of the D hold cycles, so RUN only covers the remaining D-1.
  assign w_dwell_eff = (bus.cfg_dwell == {DWELL_W{1'b0}}) ? {{(DWELL_W-1){1'b0}}, 1'b1} : bus.cfg_dwell;
  assign w_dwell_is1 = (w_dwell_eff == {{(DWELL_W-1){1'b0}}, 1'b1});
  assign w_reload    = w_dwell_eff - {{(DWELL_W-2){1'b0}}, 2'b10};
  assign w_cfg_bad   = (bus.cfg_step_ftw == {FTW_W{1'b0}}) || (bus.cfg_start_ftw > bus.cfg_stop_ftw);

  // Extra MSB catches carry/borrow so the word can never wrap outside [start, stop].
  assign w_up_sum  = {1'b0, r_ftw} + {1'b0, r_step};
  assign w_dn_diff = {1'b0, r_ftw} - {1'b0, r_step};
  assign w_up_next = (w_up_sum >= {1'b0, r_stop}) ? r_stop : w_up_sum[FTW_W-1:0];
  assign w_dn_next = (w_dn_diff[FTW_W] || (w_dn_diff[FTW_W-1:0] <= r_start)) ? r_start
                                                                             : w_dn_diff[FTW_W-1:0];

  // Next tuning word and direction at the end of the current dwell.
  always_comb begin
    w_step_ftw      = r_ftw;
    w_step_dir_down = r_dir_down;
    w_step_fin      = 1'b0;
    if (!r_dir_down) begin
      if (r_ftw == r_stop) begin
        case (r_mode)
          2'd1: begin
            w_step_ftw      = r_start;
            w_step_dir_down = 1'b0;
          end
          2'd2: begin
            w_step_ftw      = w_dn_next;
            w_step_dir_down = 1'b1;
          end
          default: begin
            w_step_fin = 1'b1;
          end
        endcase
      end else begin
        w_step_ftw      = w_up_next;
        w_step_dir_down = 1'b0;
      end
    end else begin
      if (r_ftw == r_start) begin
        w_step_ftw      = w_up_next;
        w_step_dir_down = 1'b0;
      end else begin
        w_step_ftw      = w_dn_next;
        w_step_dir_down = 1'b1;
      end
    end
  end

  // Sweep FSM with registered outputs; abort overrides everything except reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_start    <= {FTW_W{1'b0}};
      r_stop     <= {FTW_W{1'b0}};
      r_step     <= {FTW_W{1'b0}};
      r_mode     <= 2'd0;
      r_single   <= 1'b0;
      r_reload   <= {DWELL_W{1'b0}};
      r_cnt      <= {DWELL_W{1'b0}};
      r_dir_down <= 1'b0;
      r_ftw      <= {FTW_W{1'b0}};
      r_valid    <= 1'b0;
      r_pclr     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_pclr  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      if (bus.abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_cnt   <= {DWELL_W{1'b0}};
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              if (w_cfg_bad) begin
                r_err <= 1'b1;
              end else begin
                r_start    <= bus.cfg_start_ftw;
                r_stop     <= bus.cfg_stop_ftw;
                r_step     <= bus.cfg_step_ftw;
                r_mode     <= (bus.cfg_mode == 2'd3) ? 2'd0 : bus.cfg_mode;
                r_single   <= w_dwell_is1;
                r_reload   <= w_reload;
                r_dir_down <= 1'b0;
                r_ftw      <= bus.cfg_start_ftw;
                r_valid    <= 1'b1;
                r_pclr     <= 1'b1;
                r_busy     <= 1'b1;
                if (w_dwell_is1) begin
                  r_state <= S_STEP;
                end else begin
                  r_state <= S_RUN;
                  r_cnt   <= w_reload;
                end
              end
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_RUN: begin
            if (r_cnt == {DWELL_W{1'b0}}) begin
              r_state <= S_STEP;
            end else begin
              r_cnt <= r_cnt - {{(DWELL_W-1){1'b0}}, 1'b1};
            end
          end
          S_STEP: begin
            if (w_step_fin) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_ftw      <= w_step_ftw;
              r_dir_down <= w_step_dir_down;
              r_valid    <= 1'b1;
              if (r_single) begin
                r_state <= S_STEP;
              end else begin
                r_state <= S_RUN;
                r_cnt   <= r_reload;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.ftw_out   = r_ftw;
  assign bus.ftw_valid = r_valid;
  assign bus.phase_clr = r_pclr;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: directed sweeps push expected output events, a monitor pops and checks.
module tb_dds_sweep_ctrl;

  typedef struct {
    int          cyc;
    logic [31:0] ftw;
    logic        v;
    logic        p;
    logic        d;
    logic        e;
    logic        b;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  exp_t q[$];

  dds_sweep_ctrl_if #(.FTW_W(32), .DWELL_W(16)) bus ();

  dds_sweep_ctrl #(.FTW_W(32), .DWELL_W(16)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(input int c, input logic [31:0] f, input logic v, input logic p,
                               input logic d, input logic e, input logic b);
    exp_t x;
    x.cyc = c; x.ftw = f; x.v = v; x.p = p; x.d = d; x.e = e; x.b = b;
    q.push_back(x);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every output event must match the head of the expectation queue.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (bus.ftw_valid || bus.phase_clr || bus.done || bus.err) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event cyc=%0d ftw=%h v=%b p=%b d=%b e=%b b=%b",
                   cyc, bus.ftw_out, bus.ftw_valid, bus.phase_clr, bus.done, bus.err, bus.busy);
        end else begin
          x = q.pop_front();
          if (x.cyc != cyc || bus.ftw_out !== x.ftw || bus.ftw_valid !== x.v || bus.phase_clr !== x.p ||
              bus.done !== x.d || bus.err !== x.e || bus.busy !== x.b) begin
            n_bad++;
            $display("FAIL event actual cyc=%0d ftw=%h v%b p%b d%b e%b b%b required cyc=%0d ftw=%h v%b p%b d%b e%b b%b",
                     cyc, bus.ftw_out, bus.ftw_valid, bus.phase_clr, bus.done, bus.err, bus.busy,
                     x.cyc, x.ftw, x.v, x.p, x.d, x.e, x.b);
          end
        end
      end
    end
  end

  task automatic arm(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                     input logic [15:0] dw, input logic [1:0] m, output int ts);
    @(negedge clk);
    bus.cfg_start_ftw = s;
    bus.cfg_stop_ftw  = e;
    bus.cfg_step_ftw  = st;
    bus.cfg_dwell     = dw;
    bus.cfg_mode      = m;
    bus.start         = 1'b1;
    ts = cyc + 1;
  endtask

  task automatic release_start();
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic run_ramp(input logic [31:0] step, input logic [31:0] v1, input logic [31:0] v2,
                          input bit poke_busy);
    int ts;
    arm(32'd100, 32'd130, step, 16'd2, 2'd0, ts);
    push(ts,     32'd100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    push(ts + 2, v1,      1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    push(ts + 4, v2,      1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    push(ts + 6, 32'd130, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    push(ts + 8, 32'd130, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    release_start();
    if (poke_busy) begin
      wait_to(ts + 2);
      bus.cfg_start_ftw = 32'd5;
      bus.cfg_stop_ftw  = 32'd9;
      bus.cfg_step_ftw  = 32'd1;
      bus.cfg_dwell     = 16'd7;
      bus.cfg_mode      = 2'd1;
      bus.start         = 1'b1;
      release_start();
    end
    wait_to(ts + 9);
    chk("ramp_busy_end", {31'd0, bus.busy}, 32'd0);
    chk("ramp_ftw_end", bus.ftw_out, 32'd130);
    chk("ramp_queue_empty", q.size(), 32'd0);
  endtask

  initial begin
    int ts;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.cfg_start_ftw = 32'd0;
    bus.cfg_stop_ftw  = 32'd0;
    bus.cfg_step_ftw  = 32'd0;
    bus.cfg_dwell     = 16'd0;
    bus.cfg_mode      = 2'd0;
    bus.start         = 1'b0;
    bus.abort         = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ftw", bus.ftw_out, 32'd0);
    chk("reset_flags", {26'd0, bus.busy, bus.ftw_valid, bus.phase_clr, bus.done, bus.err, 1'b0}, 32'd0);

    // Single ramp, with a start while busy carrying different config.
    run_ramp(32'd10, 32'd110, 32'd120, 1'b1);
    // Clamp at stop.
    run_ramp(32'd12, 32'd112, 32'd124, 1'b0);

    // Triangle, dwell 1, then abort.
    arm(32'd0, 32'd20, 32'd10, 16'd1, 2'd2, ts);
    push(ts,     32'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    push(ts + 1, 32'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    push(ts + 2, 32'd20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    push(ts + 3, 32'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    push(ts + 4, 32'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    push(ts + 5, 32'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    push(ts + 6, 32'd20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    release_start();
    wait_to(ts + 6);
    bus.abort = 1'b1;
    release_start();
    chk("tri_abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("tri_abort_ftw", bus.ftw_out, 32'd20);
    @(negedge clk);
    chk("tri_queue_empty", q.size(), 32'd0);

    // Sawtooth near the top of the range: no wrap-around.
    arm(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd3, 2'd1, ts);
    push(ts,      32'hFFFF_FFF0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    push(ts + 3,  32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    push(ts + 6,  32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    push(ts + 9,  32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    push(ts + 12, 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    release_start();
    wait_to(ts + 12);
    bus.abort = 1'b1;
    release_start();
    chk("saw_abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("saw_abort_ftw", bus.ftw_out, 32'hFFFF_FFF0);

    // Rejections: zero step, then start above stop.
    arm(32'd10, 32'd20, 32'd0, 16'd2, 2'd0, ts);
    push(ts, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    release_start();
    wait_to(ts + 2);
    chk("rej_step0_busy", {31'd0, bus.busy}, 32'd0);
    arm(32'd50, 32'd40, 32'd1, 16'd2, 2'd0, ts);
    push(ts, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    release_start();
    wait_to(ts + 2);
    chk("rej_order_busy", {31'd0, bus.busy}, 32'd0);
    chk("rej_queue_empty", q.size(), 32'd0);

    // start==stop, dwell 0 (treated as 1), reserved mode 3 (treated as single).
    arm(32'd77, 32'd77, 32'd5, 16'd0, 2'd3, ts);
    push(ts,     32'd77, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    push(ts + 1, 32'd77, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    release_start();
    wait_to(ts + 3);
    chk("eq_busy", {31'd0, bus.busy}, 32'd0);
    chk("eq_queue_empty", q.size(), 32'd0);

    // abort together with start in IDLE: start dropped.
    arm(32'd100, 32'd130, 32'd10, 16'd2, 2'd0, ts);
    bus.abort = 1'b1;
    release_start();
    wait_to(ts + 3);
    chk("abort_start_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_start_ftw", bus.ftw_out, 32'd77);

    // Reset during the 110 dwell, then a clean ramp.
    arm(32'd100, 32'd130, 32'd10, 16'd2, 2'd0, ts);
    push(ts,     32'd100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    push(ts + 2, 32'd110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    release_start();
    wait_to(ts + 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_ftw", bus.ftw_out, 32'd0);
    chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    run_ramp(32'd10, 32'd110, 32'd120, 1'b0);

    repeat (3) @(negedge clk);
    chk("final_queue_empty", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Frequency-sweep sequencer for the DDS core. It generates the frequency tuning word (FTW) stream that drives the DDS phase accumulator: it steps from a start FTW to a stop FTW in fixed increments, holding each value for a programmable dwell. Single, sawtooth-repeat and triangle modes are supported. It sits between the register/control logic and the DDS accumulator, in the same clock domain as the accumulator.

Parameters:
FTW_W, 32, width of tuning words
DWELL_W, 16, width of dwell counter

Ports:
CLK  in  1  system clock (single clock domain)
RST  in  1  synchronous reset, active-high
cfg_start_ftw  in  FTW_W  first FTW of the sweep
cfg_stop_ftw  in  FTW_W  final FTW of the sweep
cfg_step_ftw  in  FTW_W  increment per step
cfg_dwell  in  DWELL_W  cycles each FTW is held; 0 is treated as 1
cfg_mode  in  2  0=single, 1=sawtooth repeat, 2=triangle, 3=reserved (treated as 0)
start  in  1  1-cycle request, sampled only in IDLE
abort  in  1  stop sweep immediately
ftw_out  out  FTW_W  tuning word to the DDS accumulator
ftw_valid  out  1  1-cycle pulse when ftw_out changes or reloads
phase_clr  out  1  1-cycle pulse to clear the DDS phase accumulator
busy  out  1  sweep in progress
done  out  1  1-cycle pulse on normal completion (mode 0 only)
err  out  1  1-cycle pulse on rejected start

Behaviour:
- Reset: ftw_out=0; ftw_valid, phase_clr, busy, done and err all 0; state IDLE; dwell counter 0; direction=up.
- States: IDLE, RUN (holding the current FTW while the dwell counter runs), STEP (computes the next FTW for one cycle; this cycle is folded into the dwell so hold time is exact).
- Config latch: all cfg_* inputs are captured on the accepted start. Later changes to cfg_* are ignored until the next start.
- Start rejection: start in IDLE with cfg_step_ftw==0 or cfg_start_ftw>cfg_stop_ftw gives err=1 on the next cycle. State stays IDLE and ftw_out is unchanged.
- Accepted start, sampled at cycle t:
  - At t+1: ftw_out=cfg_start_ftw, ftw_valid=1, phase_clr=1, busy=1.
  - Every FTW value is held exactly D=max(cfg_dwell,1) cycles, then the next value appears with ftw_valid=1.
- Step arithmetic: done in FTW_W+1 bits.
  - Up: next=cur+step; if next>=stop (including carry-out), next=stop.
  - Down (triangle only): if cur-step<=start or borrow, next=start.
  - ftw_out never leaves [start, stop].
- End of stop-value dwell:
  - Mode 0: done=1 and busy=0 in the same cycle; go to IDLE; ftw_out holds stop.
  - Mode 1: ftw_out=start, ftw_valid=1, no phase_clr; continue.
  - Mode 2: set direction=down and step downward.
- Triangle, end of start-value dwell while direction=down: set direction=up and step upward. The endpoints are not repeated: each endpoint is held for one dwell only.
- start==stop:
  - Mode 0: single value held D cycles, then done.
  - Modes 1 and 2: value held continuously with a ftw_valid pulse every D cycles.
- start while busy: ignored (no err).
- abort:
  - Highest priority, sampled in any state. The next cycle is IDLE with busy=0.
  - ftw_out holds its last value; no done and no ftw_valid.
  - abort and start in the same IDLE cycle: abort wins and start is dropped.
- RST mid-sweep: returns all outputs to their reset values on the next edge.
- ftw_valid, phase_clr, done and err are registered single-cycle pulses, never held.

Test Plan:
- Single ramp: start=100, stop=130, step=10, dwell=2, mode 0, start at t -> ftw_out 100@t+1..t+2, 110@t+3..t+4, 120@t+5..t+6, 130@t+7..t+8. ftw_valid at t+1, t+3, t+5, t+7; phase_clr at t+1 only; done and busy low at t+9.
- Clamp: step=12, others as above -> sequence 100, 112, 124, 130, then done.
- Triangle: start=0, stop=20, step=10, dwell=1, mode 2 -> per-cycle sequence 0, 10, 20, 10, 0, 10, 20 …. busy stays 1 and done never asserts; then abort -> busy=0 next cycle with ftw_out frozen.
- Sawtooth with wrap guard: start=0xFFFF_FFF0, stop=0xFFFF_FFFF, step=0x20, dwell=3, mode 1 -> 0xFFFF_FFF0 (3 cycles), 0xFFFF_FFFF (3 cycles), 0xFFFF_FFF0 …. No wrap to a small value, and phase_clr only on the first cycle.
- Rejection: step=0 -> err pulse, busy stays 0. start=50, stop=40 -> err pulse. start asserted while busy -> no effect on the sequence.
- Reset mid-sweep: RST during the 110 dwell -> next cycle ftw_out=0, busy=0. A subsequent start runs the ramp exactly as in the single-ramp scenario.
